// File: rtl/spi_gyro_responder_if.sv
// SPI pin bundle between a gyro-style SPI master and the register-file responder.
interface spi_gyro_responder_if;
   logic sclk;
   logic cs;
   logic mosi;
   logic miso;
   logic miso_oe;

   modport master (output sclk, output cs, output mosi, input miso, input miso_oe);
   modport slave  (input sclk, input cs, input mosi, output miso, output miso_oe);
endinterface

// File: rtl/spi_gyro_responder.sv
// SPI mode-3 slave modelling the L3G4200D register interface of the Pmod GYRO.
// Axis samples are snapshotted at chip-select fall so burst reads stay coherent.
module spi_gyro_responder #(
   parameter logic [7:0] WHO_AM_I_VAL = 8'hD3,
   parameter logic [7:0] CTRL1_RST    = 8'h07
) (
   input  logic                 clk,
   input  logic                 rst,
   spi_gyro_responder_if.slave  spi,
   input  logic                 sample_valid,
   input  logic [15:0]          x_sample,
   input  logic [15:0]          y_sample,
   input  logic [15:0]          z_sample,
   output logic [7:0]           ctrl_reg1,
   output logic                 frame_done
);
   localparam int unsigned BYTE_W   = 8;
   localparam int unsigned ADDR_W   = 6;
   localparam int unsigned CNT_W    = 3;
   localparam int unsigned NUM_CTRL = 5;
   localparam int unsigned SAMPLE_W = 48;

   localparam logic [ADDR_W-1:0] A_WHO_AM_I = 6'h0F;
   localparam logic [ADDR_W-1:0] A_CTRL1    = 6'h20;
   localparam logic [ADDR_W-1:0] A_CTRL5    = 6'h24;
   localparam logic [ADDR_W-1:0] A_STATUS   = 6'h27;
   localparam logic [ADDR_W-1:0] A_OUT_X_L  = 6'h28;
   localparam logic [ADDR_W-1:0] A_OUT_Z_H  = 6'h2D;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_WR_DATA,
      ST_RD_DATA,
      ST_WAIT_CS
   } state_e;

   state_e                            state_q, state_d;
   logic [2:0]                        sclk_sync_q, sclk_sync_d;
   logic [2:0]                        cs_sync_q, cs_sync_d;
   logic [1:0]                        mosi_sync_q, mosi_sync_d;
   logic [CNT_W-1:0]                  bit_cnt_q, bit_cnt_d;
   logic [BYTE_W-2:0]                 sh_in_q, sh_in_d;
   logic [BYTE_W-1:0]                 sh_out_q, sh_out_d;
   logic [ADDR_W-1:0]                 addr_q, addr_d;
   logic                              ms_q, ms_d;
   logic                              rd_2d_q, rd_2d_d;
   logic                              miso_q, miso_d;
   logic                              miso_oe_q, miso_oe_d;
   logic                              frame_done_q, frame_done_d;
   logic                              zyxda_q, zyxda_d;
   logic [NUM_CTRL-1:0][BYTE_W-1:0]   ctrl_q, ctrl_d;
   logic [SAMPLE_W-1:0]               live_q, live_d;
   logic [SAMPLE_W-1:0]               snap_q, snap_d;

   logic              sclk_rise, sclk_fall, cs_rise, cs_fall, last_bit;
   logic [BYTE_W-1:0] byte_in;
   logic [BYTE_W-1:0] rd_byte;
   logic [ADDR_W-1:0] next_addr;

   // Register-file read mux; OUT_* bytes come from the per-transaction snapshot.
   function automatic logic [BYTE_W-1:0] reg_read(
      input logic [ADDR_W-1:0]               a,
      input logic [SAMPLE_W-1:0]             snap,
      input logic [NUM_CTRL-1:0][BYTE_W-1:0] ctrl,
      input logic                            zyxda
   );
      logic [BYTE_W-1:0] v;
      v = '0;
      if (a == A_WHO_AM_I) begin
         v = WHO_AM_I_VAL;
      end else if (a >= A_CTRL1 && a <= A_CTRL5) begin
         v = ctrl[CNT_W'(a - A_CTRL1)];
      end else if (a == A_STATUS) begin
         v = {4'b0000, zyxda, 3'b000};
      end else if (a >= A_OUT_X_L && a <= A_OUT_Z_H) begin
         v = snap[{CNT_W'(a - A_OUT_X_L), 3'b000} +: BYTE_W];
      end
      return v;
   endfunction

   assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
   assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
   assign cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];
   assign cs_fall   = ~cs_sync_q[1] & cs_sync_q[2];
   assign byte_in   = {sh_in_q, mosi_sync_q[1]};
   assign last_bit  = (bit_cnt_q == CNT_W'(7));
   assign next_addr = ms_q ? addr_q + ADDR_W'(1) : addr_q;

   always_comb begin
      sclk_sync_d  = {sclk_sync_q[1:0], spi.sclk};
      cs_sync_d    = {cs_sync_q[1:0], spi.cs};
      mosi_sync_d  = {mosi_sync_q[0], spi.mosi};
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      sh_in_d      = sh_in_q;
      sh_out_d     = sh_out_q;
      addr_d       = addr_q;
      ms_d         = ms_q;
      rd_2d_d      = rd_2d_q;
      miso_d       = miso_q;
      miso_oe_d    = miso_oe_q;
      frame_done_d = 1'b0;
      ctrl_d       = ctrl_q;
      live_d       = live_q;
      snap_d       = snap_q;
      zyxda_d      = zyxda_q;
      rd_byte      = '0;

      if (sample_valid) begin
         live_d = {z_sample, y_sample, x_sample};
      end

      case (state_q)
         ST_IDLE: begin
            miso_oe_d = 1'b0;
            if (cs_fall) begin
               state_d   = ST_CMD;
               bit_cnt_d = '0;
               snap_d    = live_q;
               rd_2d_d   = 1'b0;
            end
         end
         ST_CMD: begin
            if (sclk_rise) begin
               sh_in_d   = byte_in[BYTE_W-2:0];
               bit_cnt_d = bit_cnt_q + CNT_W'(1);
               if (last_bit) begin
                  ms_d   = byte_in[6];
                  addr_d = byte_in[ADDR_W-1:0];
                  if (byte_in[7]) begin
                     rd_byte   = reg_read(byte_in[ADDR_W-1:0], snap_q, ctrl_q, zyxda_q);
                     sh_out_d  = rd_byte;
                     miso_d    = rd_byte[BYTE_W-1];
                     miso_oe_d = 1'b1;
                     state_d   = ST_RD_DATA;
                  end else begin
                     state_d = ST_WR_DATA;
                  end
               end
            end
         end
         ST_RD_DATA: begin
            // Each fall drives the current MSB, so the first fall re-drives the preloaded bit.
            if (sclk_fall) begin
               miso_d   = sh_out_q[BYTE_W-1];
               sh_out_d = {sh_out_q[BYTE_W-2:0], 1'b0};
            end
            if (sclk_rise) begin
               bit_cnt_d = bit_cnt_q + CNT_W'(1);
               if (last_bit) begin
                  if (addr_q == A_OUT_Z_H) begin
                     rd_2d_d = 1'b1;
                  end
                  addr_d   = next_addr;
                  rd_byte  = reg_read(next_addr, snap_q, ctrl_q, zyxda_q);
                  sh_out_d = rd_byte;
                  miso_d   = rd_byte[BYTE_W-1];
               end
            end
         end
         ST_WR_DATA: begin
            if (sclk_rise) begin
               sh_in_d   = byte_in[BYTE_W-2:0];
               bit_cnt_d = bit_cnt_q + CNT_W'(1);
               if (last_bit) begin
                  if (addr_q >= A_CTRL1 && addr_q <= A_CTRL5) begin
                     ctrl_d[CNT_W'(addr_q - A_CTRL1)] = byte_in;
                  end
                  addr_d = next_addr;
               end
            end
         end
         ST_WAIT_CS: begin
            miso_oe_d = 1'b0;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Chip-select release ends any frame and drops a partial byte.
      if (cs_rise) begin
         state_d      = ST_IDLE;
         miso_oe_d    = 1'b0;
         miso_d       = 1'b1;
         frame_done_d = 1'b1;
         bit_cnt_d    = '0;
         if (rd_2d_q) begin
            zyxda_d = 1'b0;
         end
      end
      if (sample_valid) begin
         zyxda_d = 1'b1;
      end
   end

   // Synchronisers keep tracking the pins through reset so the post-reset state sees real cs.
   always_ff @(posedge clk) begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= cs_sync_q[1] ? ST_IDLE : ST_WAIT_CS;
         bit_cnt_q    <= '0;
         sh_in_q      <= '0;
         sh_out_q     <= '0;
         addr_q       <= '0;
         ms_q         <= 1'b0;
         rd_2d_q      <= 1'b0;
         miso_q       <= 1'b1;
         miso_oe_q    <= 1'b0;
         frame_done_q <= 1'b0;
         zyxda_q      <= 1'b0;
         ctrl_q       <= {32'h0000_0000, CTRL1_RST};
         live_q       <= '0;
         snap_q       <= '0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         sh_in_q      <= sh_in_d;
         sh_out_q     <= sh_out_d;
         addr_q       <= addr_d;
         ms_q         <= ms_d;
         rd_2d_q      <= rd_2d_d;
         miso_q       <= miso_d;
         miso_oe_q    <= miso_oe_d;
         frame_done_q <= frame_done_d;
         zyxda_q      <= zyxda_d;
         ctrl_q       <= ctrl_d;
         live_q       <= live_d;
         snap_q       <= snap_d;
      end
   end

   assign spi.miso    = miso_q;
   assign spi.miso_oe = miso_oe_q;
   assign ctrl_reg1   = ctrl_q[0];
   assign frame_done  = frame_done_q;
endmodule

// File: tb/tb_spi_gyro_responder.sv
// Bench for spi_gyro_responder: bit-banged mode-3 master against a byte-level register model.
module tb_spi_gyro_responder;
   localparam int unsigned HALF      = 6;
   localparam logic [7:0]  WHO       = 8'hD3;
   localparam logic [7:0]  CTRL1_RST = 8'h07;

   logic        clk = 1'b0;
   logic        rst;
   logic        sample_valid;
   logic [15:0] x_sample, y_sample, z_sample;
   logic [7:0]  ctrl_reg1;
   logic        frame_done;

   spi_gyro_responder_if spi_if ();

   spi_gyro_responder #(.WHO_AM_I_VAL(WHO), .CTRL1_RST(CTRL1_RST)) dut (
      .clk          (clk),
      .rst          (rst),
      .spi          (spi_if),
      .sample_valid (sample_valid),
      .x_sample     (x_sample),
      .y_sample     (y_sample),
      .z_sample     (z_sample),
      .ctrl_reg1    (ctrl_reg1),
      .frame_done   (frame_done)
   );

   always #5 clk = ~clk;

   int fd_cnt = 0;
   always @(negedge clk) if (frame_done) fd_cnt++;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state
   logic [7:0] m_ctrl [5];
   logic [7:0] m_live [6];
   logic [7:0] m_snap [6];
   bit         m_zyxda;

   logic [7:0] tx_b [12];
   logic [7:0] rx_b [12];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_ctrl[0] = CTRL1_RST;
      for (int i = 1; i < 5; i++) m_ctrl[i] = 8'h00;
      for (int i = 0; i < 6; i++) begin
         m_live[i] = 8'h00;
         m_snap[i] = 8'h00;
      end
      m_zyxda = 1'b0;
   endtask

   function automatic logic [7:0] m_read(input int a);
      if (a == 'h0F) return WHO;
      if (a >= 'h20 && a <= 'h24) return m_ctrl[a - 'h20];
      if (a == 'h27) return m_zyxda ? 8'h08 : 8'h00;
      if (a >= 'h28 && a <= 'h2D) return m_snap[a - 'h28];
      return 8'h00;
   endfunction

   // One-cycle sample strobe; call on a falling clk edge.
   task automatic load_live(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
      x_sample = x; y_sample = y; z_sample = z;
      sample_valid = 1'b1;
      m_live[0] = x[7:0]; m_live[1] = x[15:8];
      m_live[2] = y[7:0]; m_live[3] = y[15:8];
      m_live[4] = z[7:0]; m_live[5] = z[15:8];
      m_zyxda = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
   endtask

   task automatic sclk_bit(input logic b, output logic mi, output logic oe);
      spi_if.sclk = 1'b0;
      spi_if.mosi = b;
      repeat (HALF) @(negedge clk);
      mi = spi_if.miso;
      oe = spi_if.miso_oe;
      spi_if.sclk = 1'b1;
      repeat (HALF) @(negedge clk);
   endtask

   // Full frame from tx_b: nbytes whole bytes plus 'extra' trailing bits.
   task automatic frame(input string tag, input int nbytes, input int extra, input int sv_bit,
                        input logic [15:0] sx, input logic [15:0] sy, input logic [15:0] sz,
                        input bit sv_end);
      logic [7:0] exp_b [12];
      logic [7:0] cur;
      logic       rw, ms, mi, oe;
      int         a, fd0, oe_bad, nbits;
      bit         hit;
      rw = tx_b[0][7];
      ms = tx_b[0][6];
      a  = int'(tx_b[0][5:0]);
      m_snap = m_live;
      hit = 0;
      for (int k = 1; k < nbytes; k++) begin
         if (rw) begin
            exp_b[k] = m_read(a);
            if (a == 'h2D) hit = 1;
         end else if (a >= 'h20 && a <= 'h24) begin
            m_ctrl[a - 'h20] = tx_b[k];
         end
         if (ms) a = (a + 1) % 64;
      end

      fd0 = fd_cnt;
      oe_bad = 0;
      nbits = nbytes * 8 + extra;
      spi_if.cs = 1'b0;
      repeat (HALF) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         if (i == sv_bit) load_live(sx, sy, sz);
         cur = tx_b[i / 8];
         sclk_bit(cur[7 - (i % 8)], mi, oe);
         if (oe !== ((rw && i >= 8) ? 1'b1 : 1'b0)) oe_bad++;
         rx_b[i / 8] = {rx_b[i / 8][6:0], mi};
      end
      repeat (HALF) @(negedge clk);
      spi_if.cs = 1'b1;
      if (hit) m_zyxda = 1'b0;
      if (sv_end) begin
         repeat (2) @(negedge clk);
         load_live(sx, sy, sz);
      end
      repeat (8) @(negedge clk);

      if (rw) for (int k = 1; k < nbytes; k++) chk($sformatf("%s_rd%0d", tag, k), rx_b[k], exp_b[k]);
      chk({tag, "_oe_frame"}, oe_bad, 0);
      chk({tag, "_oe_idle"}, spi_if.miso_oe, 0);
      chk({tag, "_frame_done"}, fd_cnt - fd0, 1);
      chk({tag, "_ctrl1"}, ctrl_reg1, m_ctrl[0]);
   endtask

   task automatic simple(input string tag, input logic [7:0] c, input logic [7:0] d,
                         input int nbytes, input int extra);
      tx_b[0] = c;
      for (int k = 1; k < 12; k++) tx_b[k] = d;
      frame(tag, nbytes, extra, -1, 16'h0, 16'h0, 16'h0, 1'b0);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: run did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] cur;
      logic       mi, oe;
      int         oe_bad;
      logic [5:0] ra;

      rst = 1'b1;
      sample_valid = 1'b0;
      x_sample = '0; y_sample = '0; z_sample = '0;
      spi_if.cs = 1'b1; spi_if.sclk = 1'b1; spi_if.mosi = 1'b0;
      model_reset();
      repeat (6) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_miso", spi_if.miso, 1);
      chk("rst_miso_oe", spi_if.miso_oe, 0);
      chk("rst_ctrl1", ctrl_reg1, CTRL1_RST);
      chk("rst_frame_done", frame_done, 0);

      simple("who", 8'h8F, 8'h00, 2, 0);
      chk("who_const", rx_b[1], 8'hD3);
      simple("wr_ctrl1", 8'h20, 8'h0F, 2, 0);
      chk("wr_ctrl1_const", ctrl_reg1, 8'h0F);
      simple("rd_ctrl1", 8'hA0, 8'h00, 2, 0);
      simple("wr_who", 8'h0F, 8'h55, 2, 0);
      simple("rd_who", 8'h8F, 8'h00, 2, 0);

      load_live(16'h1234, 16'hABCD, 16'h0F0F);
      simple("status_pre", 8'hA7, 8'h00, 2, 0);
      chk("status_pre_const", rx_b[1], 8'h08);
      simple("out6", 8'hE8, 8'h00, 7, 0);
      chk("out6_x_l_const", rx_b[1], 8'h34);
      chk("out6_y_h_const", rx_b[4], 8'hAB);
      simple("status_post", 8'hA7, 8'h00, 2, 0);
      chk("status_post_const", rx_b[1], 8'h00);

      load_live(16'h1234, 16'hABCD, 16'h0F0F);
      tx_b[0] = 8'hE8;
      frame("out6_mid", 7, 0, 20, 16'hFFFF, 16'hABCD, 16'h0F0F, 1'b0);
      tx_b[0] = 8'hE8;
      frame("out6_setwins", 7, 0, -1, 16'hFFFF, 16'hABCD, 16'h0F0F, 1'b1);
      chk("setwins_x_h_const", rx_b[2], 8'hFF);
      simple("status_setwins", 8'hA7, 8'h00, 2, 0);

      simple("wrap", 8'hFF, 8'h00, 3, 0);
      simple("zh_no_ms", 8'hAD, 8'h00, 3, 0);
      simple("part_wr", 8'h20, 8'hAA, 1, 4);

      // Reset in the middle of a read with cs held low
      spi_if.cs = 1'b0;
      repeat (HALF) @(negedge clk);
      cur = 8'h8F;
      for (int i = 0; i < 8; i++) sclk_bit(cur[7 - i], mi, oe);
      for (int i = 0; i < 4; i++) sclk_bit(1'b0, mi, oe);
      chk("rst_mid_pre_oe", oe, 1);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
      repeat (4) @(negedge clk);
      chk("rst_mid_oe", spi_if.miso_oe, 0);
      oe_bad = 0;
      cur = 8'h20;
      for (int i = 0; i < 8; i++) begin
         sclk_bit(cur[7 - i], mi, oe);
         if (oe !== 1'b0) oe_bad++;
      end
      cur = 8'hAA;
      for (int i = 0; i < 8; i++) begin
         sclk_bit(cur[7 - i], mi, oe);
         if (oe !== 1'b0) oe_bad++;
      end
      chk("rst_wait_oe", oe_bad, 0);
      repeat (HALF) @(negedge clk);
      spi_if.cs = 1'b1;
      repeat (8) @(negedge clk);
      chk("rst_wait_ctrl1", ctrl_reg1, CTRL1_RST);
      simple("after_rst", 8'h8F, 8'h00, 2, 0);

      for (int it = 0; it < 30; it++) begin
         if ($urandom_range(0, 2) == 0)
            load_live(16'($urandom), 16'($urandom), 16'($urandom));
         case ($urandom_range(0, 3))
            0: ra = 6'($urandom);
            1: ra = 6'(6'h20 + $urandom_range(0, 4));
            2: ra = 6'(6'h27 + $urandom_range(0, 6));
            default: ra = ($urandom_range(0, 1) == 0) ? 6'h0F : 6'h25;
         endcase
         tx_b[0] = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra};
         for (int k = 1; k < 12; k++) tx_b[k] = 8'($urandom);
         frame($sformatf("rnd%0d", it), int'($urandom_range(1, 5)),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0,
               -1, 16'h0, 16'h0, 16'h0, 1'b0);
      end
      simple("final_status", 8'hA7, 8'h00, 2, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/spi_gyro_responder.md
Name: spi_gyro_responder

Overview:
SPI slave (mode 3) that models the Pmod GYRO (L3G4200D-style) register interface, so the gyro SPI initiator and its byte-level SPI engine can be exercised in simulation and in hardware loopback without the physical sensor. It oversamples SCLK/CS/MOSI on the system clock, decodes the command byte (R/W, MS auto-increment, 6-bit address), and serves a small register file. Axis data comes from a parallel sample port and is frozen per transaction so multi-byte reads are coherent.

Parameters:
WHO_AM_I_VAL, 8'hD3, value returned at address 0x0F
CTRL1_RST, 8'h07, reset value of CTRL_REG1 (0x20)

Ports:
clk  input  1  system clock, must be >= 8x SCLK frequency
rst  input  1  synchronous active-high reset
sclk  input  1  SPI clock from master, idles high (CPOL=1)
cs  input  1  SPI chip select, active low
mosi  input  1  master-out serial data
miso  output  1  slave-out serial data
miso_oe  output  1  high while miso is driven (tristate enable)
sample_valid  input  1  one-cycle strobe: new x/y/z sample
x_sample  input  16  X axis sample, two's complement
y_sample  input  16  Y axis sample
z_sample  input  16  Z axis sample
ctrl_reg1  output  8  current CTRL_REG1 contents
frame_done  output  1  one-cycle pulse when a transaction ends (cs rises)

Behaviour:
- Synchronisation: sclk, cs, mosi each pass a 2-flop synchroniser; edges detected on synced values. An SCLK edge is acted on 3 clk cycles after the pin edge.
- Mode 3: mosi sampled on synced SCLK rising edge; miso updated on falling edge; MSB first.
- Register map (6-bit address): 0x0F WHO_AM_I (RO); 0x20-0x24 CTRL_REG1..5 (RW; reset CTRL1_RST, others 0x00); 0x27 STATUS (RO, bit3 = ZYXDA, other bits 0); 0x28-0x2D OUT_X_L, X_H, Y_L, Y_H, Z_L, Z_H (RO, from snapshot). All other addresses read 0x00; writes there or to RO registers are ignored.
- Sample path: sample_valid loads 48-bit live register and sets ZYXDA. At cs falling edge, live register is copied to snapshot; all OUT_* reads in that transaction use the snapshot.
- ZYXDA cleared at end of any transaction that read 0x2D; sample_valid in the same cycle as the clear: set wins.
- FSM states: IDLE, CMD, WR_DATA, RD_DATA, WAIT_CS.
  - IDLE: miso_oe=0. cs falls -> CMD, bit counter=0, snapshot taken.
  - CMD: shift 8 bits. On 8th rising edge: bit7 RW (1=read), bit6 MS, bits5:0 address. RW=1 -> load shift register with reg[addr], drive its MSB immediately, miso_oe=1, -> RD_DATA. RW=0 -> WR_DATA.
  - RD_DATA: shift out on each falling edge. On the 8th rising edge of each byte: if MS, addr <= addr+1 (6-bit wrap 0x3F->0x00); load reg[addr] (same addr if MS=0) and drive its MSB.
  - WR_DATA: shift in; on 8th rising edge commit byte to reg[addr] if writable, then increment if MS.
  - Any state: cs rise -> IDLE, miso_oe=0, frame_done=1 for one cycle, partial byte discarded (no write).
  - WAIT_CS: entered after reset if synced cs is low; stays until cs high, then IDLE. No bits accepted mid-frame.
- Reset values: miso=1, miso_oe=0, ctrl_reg1=CTRL1_RST, frame_done=0, ZYXDA=0, live/snapshot=0, state IDLE or WAIT_CS as above.
- Byte order in OUT_*: low byte at even address (x_sample[7:0] at 0x28).

Test Plan:
Read 0x8F then one dummy byte -> miso returns 0xD3, miso_oe high only while cs low, frame_done pulses once.
Write 0x20, 0x0F then cs high -> ctrl_reg1=0x0F; read 0xA0 -> 0x0F; write 0x0F,0x55 -> WHO_AM_I still 0xD3.
sample_valid with x=0x1234, y=0xABCD, z=0x0F0F; read 0xE8 + 6 bytes -> 34 12 CD AB 0F 0F; STATUS (0xA7) before = 0x08, after = 0x00.
During that 6-byte read pulse sample_valid with x=0xFFFF -> all bytes unchanged; next transaction returns FF FF; ZYXDA=1 after (set wins or re-set).
Read 0xFF (MS, addr 0x3F) + 2 bytes -> 0x00 then 0x00 (wrapped to 0x00, unmapped); read 0xAD with MS=0 + 2 bytes -> Z_H twice.
Raise cs after 4 bits of write data to 0x20 -> ctrl_reg1 unchanged; assert rst mid-read with cs low -> miso_oe=0, following bits ignored until cs high, next transaction normal.
